// File: rtl/regfile_sequencer.sv
// regfile_sequencer: bulk dump/load master for the 32x32 register file.
// Purpose: streams all registers out in pairs (dump) or fills regs 0..31
// from an input stream (load), for debug/boot state save and restore.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmdValid/cmdOp/cmdReady  command handshake (cmdOp 0 = dump, 1 = load)
//   busy, done            activity flag, one-cycle completion pulse
//   outValid/outReady     dump beat handshake
//   outIndex/outData1/2   pair index k, regs 2k and 2k+1
//   inValid/inReady/inData  load word handshake
//   readReg1/2, readData1/2  register file read ports (combinational data)
//   writeReg/writeData/write register file write port
// Build option: define REGSEQ_R0_PROTECT_EN to keep reg 0 from being
// written by a load and to report it as zero in a dump.

module regfile_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  input  logic        cmdOp,
  output logic        cmdReady,
  output logic        busy,
  output logic        done,
  output logic        outValid,
  input  logic        outReady,
  output logic [3:0]  outIndex,
  output logic [31:0] outData1,
  output logic [31:0] outData2,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] inData,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        write
);

`ifdef REGSEQ_R0_PROTECT_EN
  localparam logic R0_PROTECT = 1'b1;
`else
  localparam logic R0_PROTECT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    DUMP_RD,
    DUMP_OUT,
    LOAD,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  idx;
  logic        write_q;
  logic        cmd_hs;
  logic        out_hs;
  logic        in_hs;
  logic        idx_zero;

  assign cmdReady = (state == IDLE) & ~reset;
  assign busy     = (state != IDLE);
  assign outValid = (state == DUMP_OUT);
  assign inReady  = (state == LOAD);

  assign cmd_hs   = cmdValid & cmdReady;
  assign out_hs   = outValid & outReady;
  assign in_hs    = inValid & inReady;
  assign idx_zero = (idx == 5'd0);

  // Read addresses only point at a real pair while fetching it.
  assign readReg1 = (state == DUMP_RD) ? {idx[3:0], 1'b0} : 5'd0;
  assign readReg2 = (state == DUMP_RD) ? {idx[3:0], 1'b1} : 5'd0;

  // The write strobe is registered, so a reset arriving in the cycle it
  // is presented must mask it or the reg file would still take it.
  assign write = write_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 5'd0;
      write_q   <= 1'b0;
      writeReg  <= 5'd0;
      writeData <= 32'd0;
      outData1  <= 32'd0;
      outData2  <= 32'd0;
      outIndex  <= 4'd0;
      done      <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_hs) begin
            idx   <= 5'd0;
            state <= cmdOp ? LOAD : DUMP_RD;
          end
        end
        DUMP_RD: begin
          outData1 <= (R0_PROTECT && idx_zero) ? 32'd0 : readData1;
          outData2 <= readData2;
          outIndex <= idx[3:0];
          state    <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (out_hs) begin
            if (idx == 5'd15) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 5'd1;
              state <= DUMP_RD;
            end
          end
        end
        LOAD: begin
          if (in_hs) begin
            writeReg  <= idx;
            writeData <= inData;
            write_q   <= ~(R0_PROTECT && idx_zero);
            if (idx == 5'd31) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
